// File: rtl/gray_conv_pkg.sv
// Shared definitions for the Gray-code conversion arbiter: default sizes,
// conversion-counter width/saturation value and the output-slot state type.
package gray_conv_pkg;

    localparam int GC_N_REQ_DEF = 4;
    localparam int GC_W_DEF     = 8;

    localparam int              GC_CNT_W   = 16;
    localparam logic [15:0]     GC_CNT_MAX = 16'hFFFF;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/gray_bin_conv.sv
// Purely combinational Gray-to-binary converter: binary bit k is the XOR of
// Gray bits W-1 down to k, so the MSB passes straight through.
module gray_bin_conv #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    // Each output bit is the reduction XOR of the Gray word shifted down to it
    always_comb begin
        o_bin = '0;
        for (int k = 0; k < W; k++) begin
            o_bin[k] = ^(i_gray >> k);
        end
    end

endmodule

// File: rtl/gray_conv_arb.sv
// N-requester arbiter feeding a single Gray-to-binary converter with a
// one-entry output slot (1-cycle latency, 1 result/cycle sustained).
// Define GRAY_CONV_ARB_RR_EN for round-robin arbitration; otherwise
// requester 0 has fixed highest priority and no pointer exists.
module gray_conv_arb
    import gray_conv_pkg::*;
#(
    parameter int N_REQ = GC_N_REQ_DEF,
    parameter int W     = GC_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*W-1:0]        req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [W-1:0]              out_data,
    output logic [W-1:0]              out_gray,
    output logic [$clog2(N_REQ)-1:0]  out_id,
    output logic [GC_CNT_W-1:0]       conv_cnt
);

    localparam int ID_W = $clog2(N_REQ);

    slot_state_t         r_state;
    slot_state_t         w_state_nxt;
    logic                w_slot_avail;
    logic                w_any;
    logic                w_accept;
    logic [ID_W-1:0]     w_gnt_idx;
    logic [W-1:0]        w_gray_sel;
    logic [W-1:0]        w_bin;
    logic [W-1:0]        r_out_data;
    logic [W-1:0]        r_out_gray;
    logic [ID_W-1:0]     r_out_id;
    logic [GC_CNT_W-1:0] r_cnt;

    assign out_valid    = (r_state == FULL);
    assign w_slot_avail = !out_valid || out_ready;
    // Reset is folded in so no grant can be offered while rst is high
    assign w_accept     = w_any && w_slot_avail && !rst;

`ifdef GRAY_CONV_ARB_RR_EN
    logic [ID_W-1:0] r_ptr;

    // Round-robin search starting at the pointer, wrapping modulo N_REQ
    always_comb begin
        logic [ID_W:0] w_sum;
        w_any     = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(N_REQ)) begin
                w_sum = w_sum - (ID_W+1)'(N_REQ);
            end
            if (!w_any && req_valid[w_sum[ID_W-1:0]]) begin
                w_any     = 1'b1;
                w_gnt_idx = w_sum[ID_W-1:0];
            end
        end
    end

    // Pointer moves to one past the granted requester on every accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (w_gnt_idx == ID_W'(N_REQ-1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end
`else
    // Fixed priority: scan from the top so the lowest valid index wins
    always_comb begin
        w_any     = 1'b0;
        w_gnt_idx = '0;
        for (int k = N_REQ-1; k >= 0; k--) begin
            if (req_valid[ID_W'(k)]) begin
                w_any     = 1'b1;
                w_gnt_idx = ID_W'(k);
            end
        end
    end
`endif

    // One-hot ready for the winner only when the slot can take a result
    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    // Select the winning requester's Gray word for the converter
    always_comb begin
        w_gray_sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (ID_W'(k) == w_gnt_idx) begin
                w_gray_sel = req_data[k*W +: W];
            end
        end
    end

    gray_bin_conv #(
        .W (W)
    ) u_conv (
        .i_gray (w_gray_sel),
        .o_bin  (w_bin)
    );

    // Output slot state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Slot fills on accept, empties on drain without a refill, else holds
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: if (w_accept) w_state_nxt = FULL;
            FULL: begin
                if (w_accept)       w_state_nxt = FULL;
                else if (out_ready) w_state_nxt = EMPTY;
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    // Capture converted result, original code and source index on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data <= '0;
            r_out_gray <= '0;
            r_out_id   <= '0;
        end else if (w_accept) begin
            r_out_data <= w_bin;
            r_out_gray <= w_gray_sel;
            r_out_id   <= w_gnt_idx;
        end
    end

    // Accepted-conversion counter, sticks at its maximum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept && (r_cnt != GC_CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_data = r_out_data;
    assign out_gray = r_out_gray;
    assign out_id   = r_out_id;
    assign conv_cnt = r_cnt;

endmodule
